// File: rtl/lc3b_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lc3b_mem_arbiter
// Brief    : Shares one physical memory port between the fetch (read-only)
//            and data (read/write) ports; data wins, with bounded fetch starvation.
// Revision : 1.0 - initial release
// ============================================================================
module lc3b_mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [DATA_W-1:0] pmem_wdata,
    input  logic [DATA_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic              arb_err
);

    localparam int                 c_CNT_W      = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_STARVE_MAX = c_CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_I_BUSY = 2'd1,
        ST_D_BUSY = 2'd2
    } state_t;

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_starve_cnt;
    logic                r_arb_err;
    logic                r_pmem_read;
    logic                r_pmem_write;
    logic [ADDR_W-1:0]   r_pmem_address;
    logic [DATA_W-1:0]   r_pmem_wdata;

    logic                w_d_req;
    logic                w_fetch_starved;
    logic [c_CNT_W-1:0]  w_starve_next;

    assign w_d_req         = d_read | d_write;
    assign w_fetch_starved = i_read && (r_starve_cnt == c_STARVE_MAX);
    assign w_starve_next   = (r_starve_cnt == c_STARVE_MAX) ? r_starve_cnt
                                                            : r_starve_cnt + c_CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_starve_cnt   <= '0;
            r_arb_err      <= 1'b0;
            r_pmem_read    <= 1'b0;
            r_pmem_write   <= 1'b0;
            r_pmem_address <= '0;
            r_pmem_wdata   <= '0;
        end else begin
            if (d_read && d_write)
                r_arb_err <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (w_d_req && !w_fetch_starved) begin
                        // A simultaneous read+write is executed as a write.
                        r_state        <= ST_D_BUSY;
                        r_pmem_address <= d_address;
                        r_pmem_wdata   <= d_wdata;
                        r_pmem_write   <= d_write;
                        r_pmem_read    <= ~d_write;
                        r_starve_cnt   <= i_read ? w_starve_next : '0;
                    end else if (i_read) begin
                        r_state        <= ST_I_BUSY;
                        r_pmem_address <= i_address;
                        r_pmem_read    <= 1'b1;
                        r_pmem_write   <= 1'b0;
                        r_starve_cnt   <= '0;
                    end else begin
                        r_starve_cnt   <= '0;
                    end
                end
                ST_I_BUSY, ST_D_BUSY: begin
                    if (pmem_resp) begin
                        r_state      <= ST_IDLE;
                        r_pmem_read  <= 1'b0;
                        r_pmem_write <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_pmem_read  <= 1'b0;
                    r_pmem_write <= 1'b0;
                end
            endcase
        end
    end

    // Responses are steered combinationally so the requester sees them in the pmem_resp cycle.
    assign i_resp       = pmem_resp && (r_state == ST_I_BUSY);
    assign d_resp       = pmem_resp && (r_state == ST_D_BUSY);
    assign i_rdata      = pmem_rdata;
    assign d_rdata      = pmem_rdata;
    assign pmem_read    = r_pmem_read;
    assign pmem_write   = r_pmem_write;
    assign pmem_address = r_pmem_address;
    assign pmem_wdata   = r_pmem_wdata;
    assign arb_err      = r_arb_err;

endmodule
`default_nettype wire

// File: tb/tb_lc3b_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lc3b_mem_arbiter
// Brief    : Directed and randomized scoreboard bench for lc3b_mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lc3b_mem_arbiter;

    localparam int STARVE_LIMIT = 4;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
    } dreq_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_read;
    logic [15:0] i_address;
    logic [15:0] i_rdata;
    logic        i_resp;
    logic        d_read;
    logic        d_write;
    logic [15:0] d_address;
    logic [15:0] d_wdata;
    logic [15:0] d_rdata;
    logic        d_resp;
    logic        pmem_read;
    logic        pmem_write;
    logic [15:0] pmem_address;
    logic [15:0] pmem_wdata;
    logic [15:0] pmem_rdata;
    logic        pmem_resp;
    logic        arb_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] iq[$];
    dreq_t       dq[$];

    logic        slave_en = 1'b0;
    logic        mon_en   = 1'b0;

    lc3b_mem_arbiter #(
        .ADDR_W      (16),
        .DATA_W      (16),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_read      (i_read),
        .i_address   (i_address),
        .i_rdata     (i_rdata),
        .i_resp      (i_resp),
        .d_read      (d_read),
        .d_write     (d_write),
        .d_address   (d_address),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_resp      (d_resp),
        .pmem_read   (pmem_read),
        .pmem_write  (pmem_write),
        .pmem_address(pmem_address),
        .pmem_wdata  (pmem_wdata),
        .pmem_rdata  (pmem_rdata),
        .pmem_resp   (pmem_resp),
        .arb_err     (arb_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory slave: answers each strobe after a random 0..3 cycle latency.
    int   slave_lat;
    logic slave_active = 1'b0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (slave_en) begin
                pmem_resp  = 1'b0;
                pmem_rdata = 16'($urandom);
                if (!slave_active && (pmem_read || pmem_write)) begin
                    slave_active = 1'b1;
                    slave_lat    = $urandom_range(0, 3);
                end
                if (slave_active) begin
                    if (slave_lat == 0) begin
                        pmem_resp    = 1'b1;
                        slave_active = 1'b0;
                    end else begin
                        slave_lat--;
                    end
                end
            end
        end
    end

    // Monitor: predicts each grant from the arbitration rules, pops the scoreboard.
    logic        prev_idle = 1'b0;
    logic        p_iread, p_dreq, p_dwrite;
    int          starve_m = 0;
    int          exp_side;
    int          g = 0;
    logic [15:0] g_addr;
    logic        g_wr;
    logic        done;
    logic [15:0] ia;
    dreq_t       dr;
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (prev_idle) begin
                    if (p_dreq && !(p_iread && starve_m == STARVE_LIMIT)) exp_side = 2;
                    else if (p_iread)                                      exp_side = 1;
                    else                                                   exp_side = 0;
                    // Consecutive data grants that fetch has waited behind.
                    if (exp_side == 2 && p_iread)
                        starve_m = (starve_m < STARVE_LIMIT) ? starve_m + 1 : starve_m;
                    else
                        starve_m = 0;
                    check("grant_rd", 32'(pmem_read), 32'(exp_side == 1 || (exp_side == 2 && !p_dwrite)));
                    check("grant_wr", 32'(pmem_write), 32'(exp_side == 2 && p_dwrite));
                    g_wr = 1'b0;
                    if (exp_side == 1) begin
                        if (iq.size() == 0) check("i_sb_empty", 1, 0);
                        else begin
                            ia = iq.pop_front();
                            check("i_grant_addr", 32'(pmem_address), 32'(ia));
                            g_addr = ia;
                        end
                    end else if (exp_side == 2) begin
                        if (dq.size() == 0) check("d_sb_empty", 1, 0);
                        else begin
                            dr = dq.pop_front();
                            check("d_grant_addr", 32'(pmem_address), 32'(dr.addr));
                            if (dr.we) check("d_grant_wdata", 32'(pmem_wdata), 32'(dr.wdata));
                            g_addr = dr.addr;
                            g_wr   = dr.we;
                        end
                    end
                    g = exp_side;
                end else if (g != 0) begin
                    check("hold_addr", 32'(pmem_address), 32'(g_addr));
                    check("hold_wr", 32'(pmem_write), 32'(g_wr));
                    check("hold_rd", 32'(pmem_read), 32'(!g_wr));
                end
                done = 1'b0;
                if (g != 0 && pmem_resp) begin
                    check("i_resp_route", 32'(i_resp), 32'(g == 1));
                    check("d_resp_route", 32'(d_resp), 32'(g == 2));
                    if (g == 1) check("i_rdata", 32'(i_rdata), 32'(pmem_rdata));
                    else        check("d_rdata", 32'(d_rdata), 32'(pmem_rdata));
                    done = 1'b1;
                end
                prev_idle = (g == 0);
                if (done) g = 0;
                p_iread  = i_read;
                p_dreq   = d_read | d_write;
                p_dwrite = d_write;
            end
        end
    end

    task automatic fetch_requester(input int n);
        int t;
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 1) == 0) begin
                i_read = 1'b0;
                repeat ($urandom_range(1, 4)) tick();
            end
            i_read    = 1'b1;
            i_address = 16'($urandom);
            iq.push_back(i_address);
            t = 0;
            do begin @(negedge clk); t++; end while (!i_resp && t < 300);
            if (t >= 300) check("i_timeout", 1, 0);
            tick();
        end
        i_read = 1'b0;
    endtask

    task automatic data_requester(input int n);
        int    t;
        dreq_t r;
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                d_read  = 1'b0;
                d_write = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
            end
            r.addr    = 16'($urandom);
            r.we      = 1'($urandom_range(0, 1));
            r.wdata   = 16'($urandom);
            d_address = r.addr;
            d_wdata   = r.wdata;
            d_write   = r.we;
            d_read    = ~r.we;
            dq.push_back(r);
            t = 0;
            do begin @(negedge clk); t++; end while (!d_resp && t < 300);
            if (t >= 300) check("d_timeout", 1, 0);
            tick();
        end
        d_read  = 1'b0;
        d_write = 1'b0;
    endtask

    logic exp_i;
    initial begin
        rst_n = 1'b0; i_read = 1'b0; i_address = '0; d_read = 1'b0; d_write = 1'b0;
        d_address = '0; d_wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0;
        repeat (2) tick();
        check("rst_pmem_read", 32'(pmem_read), 0);
        check("rst_pmem_write", 32'(pmem_write), 0);
        check("rst_pmem_addr", 32'(pmem_address), 0);
        check("rst_pmem_wdata", 32'(pmem_wdata), 0);
        check("rst_arb_err", 32'(arb_err), 0);
        rst_n = 1'b1;
        tick();

        // Lone fetch, memory answers 3 cycles after the strobe.
        i_read = 1'b1; i_address = 16'h1234;
        tick();
        check("lf_strobe", 32'(pmem_read), 1);
        check("lf_addr", 32'(pmem_address), 32'h1234);
        check("lf_nowrite", 32'(pmem_write), 0);
        tick(); tick();
        check("lf_early_resp", 32'(i_resp), 0);
        tick();
        pmem_resp = 1'b1; pmem_rdata = 16'hBEEF; #1;
        check("lf_iresp", 32'(i_resp), 1);
        check("lf_irdata", 32'(i_rdata), 32'hBEEF);
        check("lf_dresp", 32'(d_resp), 0);
        tick();
        pmem_resp = 1'b0; i_read = 1'b0; #1;
        check("lf_strobe_clr", 32'(pmem_read), 0);
        check("lf_iresp_clr", 32'(i_resp), 0);

        // Write held stable until pmem_resp.
        d_write = 1'b1; d_address = 16'h0040; d_wdata = 16'hA5A5;
        tick();
        check("wr_strobe", 32'(pmem_write), 1);
        check("wr_noread", 32'(pmem_read), 0);
        check("wr_addr", 32'(pmem_address), 32'h0040);
        check("wr_wdata", 32'(pmem_wdata), 32'hA5A5);
        d_address = 16'h0FFF; d_wdata = 16'h1111;
        tick();
        check("wr_hold_addr", 32'(pmem_address), 32'h0040);
        check("wr_hold_wdata", 32'(pmem_wdata), 32'hA5A5);
        check("wr_hold_strobe", 32'(pmem_write), 1);
        pmem_resp = 1'b1; #1;
        check("wr_dresp", 32'(d_resp), 1);
        check("wr_iresp", 32'(i_resp), 0);
        tick();
        pmem_resp = 1'b0; d_write = 1'b0; #1;
        check("wr_dresp_pulse", 32'(d_resp), 0);
        check("wr_strobe_clr", 32'(pmem_write), 0);

        // Contention: data first, then fetch after one idle cycle.
        i_read = 1'b1; i_address = 16'h1111; d_read = 1'b1; d_address = 16'h2222;
        tick();
        check("ct_d_first", 32'(pmem_address), 32'h2222);
        pmem_resp = 1'b1; #1;
        check("ct_dresp", 32'(d_resp), 1);
        tick();
        pmem_resp = 1'b0; d_read = 1'b0; #1;
        check("ct_idle_gap", 32'(pmem_read), 0);
        tick();
        check("ct_i_second", 32'(pmem_address), 32'h1111);
        check("ct_i_strobe", 32'(pmem_read), 1);
        pmem_resp = 1'b1; #1;
        check("ct_iresp", 32'(i_resp), 1);
        tick();
        pmem_resp = 1'b0; i_read = 1'b0;
        tick();

        // Starvation: expected grant pattern D D D D I, twice.
        i_read = 1'b1; i_address = 16'h3000; d_read = 1'b1; d_address = 16'h2000;
        for (int k = 0; k < 10; k++) begin
            tick();
            exp_i = (k % 5 == 4);
            check("sv_grant_addr", 32'(pmem_address), exp_i ? 32'h3000 : 32'(16'h2000 + 16'(k)));
            pmem_resp = 1'b1; #1;
            check("sv_iresp", 32'(i_resp), 32'(exp_i));
            check("sv_dresp", 32'(d_resp), 32'(!exp_i));
            tick();
            pmem_resp = 1'b0;
            d_address = 16'h2000 + 16'(k + 1);
        end
        i_read = 1'b0; d_read = 1'b0;
        tick();

        // Asynchronous reset during a data write; late pmem_resp is ignored.
        d_write = 1'b1; d_address = 16'h0077; d_wdata = 16'h5555;
        tick();
        check("rs_strobe", 32'(pmem_write), 1);
        #2 rst_n = 1'b0; #1;
        check("rs_write_clr", 32'(pmem_write), 0);
        check("rs_addr_clr", 32'(pmem_address), 0);
        d_write = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        pmem_resp = 1'b1; #1;
        check("rs_late_dresp", 32'(d_resp), 0);
        check("rs_late_iresp", 32'(i_resp), 0);
        tick();
        pmem_resp = 1'b0; #1;
        check("rs_stays_idle", 32'(pmem_write | pmem_read), 0);

        // Randomized traffic checked by the monitor.
        prev_idle = 1'b0; g = 0; starve_m = 0;
        slave_en = 1'b1; mon_en = 1'b1;
        fork
            fetch_requester(40);
            data_requester(80);
        join
        repeat (3) tick();
        mon_en = 1'b0; slave_en = 1'b0; pmem_resp = 1'b0;
        check("rnd_iq_drained", 32'(iq.size()), 0);
        check("rnd_dq_drained", 32'(dq.size()), 0);
        check("rnd_no_err", 32'(arb_err), 0);
        tick();

        // Read+write together: executed as a write, sticky error.
        d_read = 1'b1; d_write = 1'b1; d_address = 16'h0050; d_wdata = 16'h0F0F;
        tick();
        check("pe_write", 32'(pmem_write), 1);
        check("pe_noread", 32'(pmem_read), 0);
        check("pe_err", 32'(arb_err), 1);
        pmem_resp = 1'b1; #1;
        check("pe_dresp", 32'(d_resp), 1);
        tick();
        pmem_resp = 1'b0; d_read = 1'b0; d_write = 1'b0;
        repeat (3) tick();
        check("pe_err_sticky", 32'(arb_err), 1);
        #2 rst_n = 1'b0; #1;
        check("pe_err_reset", 32'(arb_err), 0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
